// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-outstanding instruction fetch FSM with redirect and decode handshake
module fetch_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i,
   output logic [31:0] pc_o
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [31:0] r_instr_pc;
   logic [31:0] w_instr_pc_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   // set when the response of the outstanding request belongs to a squashed path
   logic        r_drop;
   logic        w_drop_nxt;

   logic [31:0] w_target;
   logic [31:0] w_pc_inc;
   logic        w_handshake;

   // redirect targets are word aligned; the low bits are masked rather than sliced off
   assign w_target    = redirect_pc_i & 32'hFFFF_FFFC;
   assign w_pc_inc    = r_pc + 32'd4;
   assign w_handshake = r_valid & instr_ready_i;

   assign imem_req_o    = (r_state == ST_REQ);
   assign imem_addr_o   = r_pc;
   assign pc_o          = r_pc;
   assign instr_valid_o = r_valid;
   assign instr_o       = r_instr;
   assign instr_pc_o    = r_instr_pc;

   // state and datapath registers; reset abandons any outstanding request
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_VECTOR;
         r_instr    <= 32'h0;
         r_instr_pc <= 32'h0;
         r_valid    <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_instr_pc <= w_instr_pc_nxt;
         r_valid    <= w_valid_nxt;
         r_drop     <= w_drop_nxt;
      end
   end

   // next-state logic; a redirect always overrides the sequential pc and any held instruction
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_instr_nxt    = r_instr;
      w_instr_pc_nxt = r_instr_pc;
      w_valid_nxt    = r_valid;
      w_drop_nxt     = r_drop;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_REQ;
            if (redirect_i) w_pc_nxt = w_target;
         end
         ST_REQ: begin
            if (imem_gnt_i) begin
               w_state_nxt = ST_WAIT;
               if (redirect_i) begin
                  w_pc_nxt   = w_target;
                  w_drop_nxt = 1'b1;
               end
            end else if (redirect_i) begin
               w_pc_nxt = w_target;
            end
         end
         ST_WAIT: begin
            if (redirect_i) begin
               w_pc_nxt = w_target;
               if (imem_rvalid_i) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = ST_REQ;
               end else begin
                  w_drop_nxt = 1'b1;
               end
            end else if (imem_rvalid_i) begin
               if (r_drop) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = ST_REQ;
               end else begin
                  w_instr_nxt    = imem_rdata_i;
                  w_instr_pc_nxt = r_pc;
                  w_pc_nxt       = w_pc_inc;
                  w_valid_nxt    = 1'b1;
                  w_state_nxt    = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (redirect_i) begin
               w_pc_nxt    = w_target;
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_REQ;
            end else if (w_handshake) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_REQ;
            end
         end
         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed and randomized self-checking bench for fetch_controller
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i = 1'b0;
   logic [31:0] pc_o;

   int total = 0;
   int bad = 0;

   fetch_controller dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .pc_o          (pc_o)
   );

   always #5 clk = ~clk;

   // memory contents as a pure function of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   // outputs are sampled and inputs driven at the falling edge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      instr_ready_i = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset_i = 1'b0;
      step();
      step();
      reset_i = 1'b1;
   endtask

   // full fetch from state REQ at exp_addr: grant, data next cycle, optional decode stall, handshake
   task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int stall);
      logic [31:0] nxt;
      nxt = exp_addr + 32'd4;
      total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL fetch_req got=%b want=1", imem_req_o); end
      total++; if (imem_addr_o !== exp_addr) begin bad++; $display("FAIL fetch_addr got=%h want=%h", imem_addr_o, exp_addr); end
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL wait_req got=%b want=0", imem_req_o); end
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = data;
      step();
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      total++; if (instr_valid_o !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b want=1", instr_valid_o); end
      total++; if (instr_o !== data) begin bad++; $display("FAIL hold_instr got=%h want=%h", instr_o, data); end
      total++; if (instr_pc_o !== exp_addr) begin bad++; $display("FAIL hold_ipc got=%h want=%h", instr_pc_o, exp_addr); end
      total++; if (pc_o !== nxt) begin bad++; $display("FAIL hold_pc got=%h want=%h", pc_o, nxt); end
      for (int i = 0; i < stall; i++) begin
         step();
         total++; if (instr_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b want=1", i, instr_valid_o); end
         total++; if (instr_o !== data) begin bad++; $display("FAIL stall_instr cyc=%0d got=%h want=%h", i, instr_o, data); end
         total++; if (instr_pc_o !== exp_addr) begin bad++; $display("FAIL stall_ipc cyc=%0d got=%h want=%h", i, instr_pc_o, exp_addr); end
         total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL stall_req cyc=%0d got=%b want=0", i, imem_req_o); end
      end
      instr_ready_i = 1'b1;
      step();
      instr_ready_i = 1'b0;
      total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL after_hs_valid got=%b want=0", instr_valid_o); end
      total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL after_hs_req got=%b want=1", imem_req_o); end
      total++; if (imem_addr_o !== nxt) begin bad++; $display("FAIL after_hs_addr got=%h want=%h", imem_addr_o, nxt); end
   endtask

   task automatic test_reset();
      apply_reset();
      reset_i = 1'b0;
      step();
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req_o); end
      total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", instr_valid_o); end
      total++; if (instr_o !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instr_o); end
      total++; if (instr_pc_o !== 32'h0) begin bad++; $display("FAIL rst_ipc got=%h want=0", instr_pc_o); end
      total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc_o); end
      reset_i = 1'b1;
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL boot_req got=%b want=0", imem_req_o); end
      step();
      total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL first_req got=%b want=1", imem_req_o); end
   endtask

   task automatic test_first_fetch();
      do_fetch(32'h0, 32'h0000_0013, 0);
      do_fetch(32'h4, mem_word(32'h4), 0);
      do_fetch(32'h8, mem_word(32'h8), 0);
      do_fetch(32'hC, mem_word(32'hC), 0);
   endtask

   task automatic test_hold_stall();
      do_fetch(32'h10, mem_word(32'h10), 5);
   endtask

   task automatic test_redirect_wait();
      total++; if (imem_addr_o !== 32'h14) begin bad++; $display("FAIL rw_start got=%h want=00000014", imem_addr_o); end
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i    = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      step();
      redirect_i = 1'b0;
      step();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      step();
      imem_rvalid_i = 1'b0;
      total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rw_valid got=%b want=0", instr_valid_o); end
      total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL rw_req got=%b want=1", imem_req_o); end
      total++; if (imem_addr_o !== 32'h100) begin bad++; $display("FAIL rw_addr got=%h want=00000100", imem_addr_o); end
      do_fetch(32'h100, mem_word(32'h100), 0);
   endtask

   task automatic test_redirect_hold();
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(32'h104);
      step();
      imem_rvalid_i = 1'b0;
      total++; if (instr_valid_o !== 1'b1) begin bad++; $display("FAIL rh_pre_valid got=%b want=1", instr_valid_o); end
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      instr_ready_i = 1'b1;
      step();
      redirect_i    = 1'b0;
      instr_ready_i = 1'b0;
      total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rh_valid got=%b want=0", instr_valid_o); end
      total++; if (imem_addr_o !== 32'h200) begin bad++; $display("FAIL rh_addr got=%h want=00000200", imem_addr_o); end
      do_fetch(32'h200, mem_word(32'h200), 0);
   endtask

   task automatic test_wrap();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFE;
      step();
      redirect_i = 1'b0;
      total++; if (imem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_target got=%h want=fffffffc", imem_addr_o); end
      do_fetch(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 0);
   endtask

   task automatic test_async_reset();
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      #2;
      reset_i = 1'b0;
      #1;
      total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL ar_pc got=%h want=0", pc_o); end
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL ar_req got=%b want=0", imem_req_o); end
      total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", instr_valid_o); end
      total++; if (instr_o !== 32'h0) begin bad++; $display("FAIL ar_instr got=%h want=0", instr_o); end
      total++; if (instr_pc_o !== 32'h0) begin bad++; $display("FAIL ar_ipc got=%h want=0", instr_pc_o); end
      step();
      step();
      reset_i       = 1'b1;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD0_BAD0;
      step();
      total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL late_req got=%b want=1", imem_req_o); end
      total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL late_valid got=%b want=0", instr_valid_o); end
      step();
      imem_rvalid_i = 1'b0;
      total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL late_req2 got=%b want=1", imem_req_o); end
      do_fetch(32'h0, mem_word(32'h0), 0);
   endtask

   // random traffic judged against an architectural model: delivered pcs run sequentially from the last redirect
   task automatic test_random();
      int          pending = 0;
      int          delay = 0;
      int          delivered = 0;
      logic [31:0] paddr = 32'h0;
      logic [31:0] exp_pc = 32'h0;
      logic        hold_chk = 1'b0;
      logic [31:0] prev_instr = 32'h0;
      logic [31:0] prev_ipc = 32'h0;
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         total++; if (imem_addr_o !== pc_o) begin bad++; $display("FAIL rnd_addr_pc cyc=%0d got=%h want=%h", cyc, imem_addr_o, pc_o); end
         if (pending != 0) begin
            total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rnd_outstanding cyc=%0d got=%b want=0", cyc, imem_req_o); end
         end
         if (hold_chk) begin
            total++; if (instr_valid_o !== 1'b1) begin bad++; $display("FAIL rnd_hold_valid cyc=%0d got=%b want=1", cyc, instr_valid_o); end
            total++; if (instr_o !== prev_instr || instr_pc_o !== prev_ipc) begin bad++; $display("FAIL rnd_hold_data cyc=%0d got=%h@%h want=%h@%h", cyc, instr_o, instr_pc_o, prev_instr, prev_ipc); end
         end
         redirect_i    = ($urandom_range(0, 9) == 0);
         redirect_pc_i = $urandom;
         instr_ready_i = ($urandom_range(0, 2) != 0);
         imem_gnt_i    = $urandom_range(0, 1) == 1;
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom;
         if (pending != 0) begin
            if (delay == 0) begin
               imem_rvalid_i = 1'b1;
               imem_rdata_i  = mem_word(paddr);
               pending       = 0;
            end else begin
               delay--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            imem_rvalid_i = 1'b1;
         end
         if (imem_req_o && imem_gnt_i) begin
            pending = 1;
            paddr   = imem_addr_o;
            delay   = $urandom_range(0, 2);
         end
         if (redirect_i) begin
            exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
         end else if (instr_valid_o && instr_ready_i) begin
            total++; if (instr_pc_o !== exp_pc) begin bad++; $display("FAIL rnd_ipc cyc=%0d got=%h want=%h", cyc, instr_pc_o, exp_pc); end
            total++; if (instr_o !== mem_word(exp_pc)) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h want=%h", cyc, instr_o, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         hold_chk   = instr_valid_o && !instr_ready_i && !redirect_i;
         prev_instr = instr_o;
         prev_ipc   = instr_pc_o;
         step();
      end
      clear_inputs();
      total++; if (delivered < 100) begin bad++; $display("FAIL rnd_progress got=%0d want>=100", delivered); end
   endtask

   initial begin
      step();
      test_reset();
      test_first_fetch();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
